// File: rtl/driver_7seg_mux.sv
// Multiplexed 7-segment driver: one shared segment bus, one-hot digit selects,
// per-frame input snapshot, blank/blink masks, PWM brightness and dead time.
module driver_7seg_mux #(
  parameter int N_DIG     = 4,
  parameter int SEG_W     = 8,
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 4,
  parameter int BR_W      = 3,
  parameter int BLINK_FR  = 64,
  parameter int ACT_LOW   = 1
) (
  input  logic                   clk_disp,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_DIG*SEG_W-1:0] seg_in,
  input  logic [N_DIG-1:0]       blank_mask,
  input  logic [N_DIG-1:0]       blink_mask,
  input  logic [BR_W-1:0]        brightness,
  output logic [SEG_W-1:0]       catodo,
  output logic [N_DIG-1:0]       seleccion,
  output logic                   frame_start
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int FR_W  = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam int PW    = CNT_W + BR_W + 1;

  localparam logic [SEG_W-1:0] SEG_OFF  = (ACT_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [N_DIG-1:0] SEL_OFF  = (ACT_LOW != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FR - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_ON, S_TAIL} state_t;

  state_t                   r_state;
  state_t                   w_state_nx;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nx;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_idx_nx;
  logic [FR_W-1:0]          r_frame_cnt;
  logic                     r_blink_phase;
  logic                     r_frame_start;
  logic [SEG_W-1:0]         r_catodo;
  logic [N_DIG-1:0]         r_sel;

  logic [N_DIG*SEG_W-1:0]   r_seg_s;
  logic [N_DIG-1:0]         r_blank_s;
  logic [N_DIG-1:0]         r_blink_s;
  logic [BR_W-1:0]          r_br_s;

  logic                     w_slot_end;
  logic                     w_frame_wrap;
  logic                     w_fs;
  logic [BR_W-1:0]          w_br_eff;
  logic [BR_W:0]            w_br_p1;
  logic [PW-1:0]            w_prod;
  logic [PW-1:0]            w_on_end;
  logic                     w_lit;
  logic [SEG_W-1:0]         w_pat;
  logic [N_DIG-1:0]         w_sel_oh;

  assign w_slot_end   = (r_cnt == CNT_LAST);
  assign w_frame_wrap = (r_state != S_IDLE) && w_slot_end && (r_idx == IDX_LAST);
  assign w_fs         = enable && ((r_state == S_IDLE) || w_frame_wrap);

  // The slot being entered at a frame start must already use the new brightness.
  assign w_br_eff = w_fs ? brightness : r_br_s;
  assign w_br_p1  = {1'b0, w_br_eff} + (BR_W+1)'(1);
  assign w_prod   = PW'(DIV - BLANK_CYC) * PW'(w_br_p1);
  assign w_on_end = PW'(BLANK_CYC) + (w_prod >> BR_W);

  always_comb begin
    w_cnt_nx   = '0;
    w_idx_nx   = '0;
    w_state_nx = S_IDLE;
    if (enable) begin
      if (r_state != S_IDLE) begin
        w_cnt_nx = w_slot_end ? '0 : r_cnt + CNT_W'(1);
        if (w_slot_end)
          w_idx_nx = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        else
          w_idx_nx = r_idx;
      end
      if (PW'(w_cnt_nx) < PW'(BLANK_CYC))
        w_state_nx = S_DEAD;
      else if (PW'(w_cnt_nx) < w_on_end)
        w_state_nx = S_ON;
      else
        w_state_nx = S_TAIL;
    end
  end

  assign w_lit    = (r_state == S_ON) && !r_blank_s[r_idx] &&
                    !(r_blink_s[r_idx] && r_blink_phase);
  assign w_pat    = r_seg_s[r_idx*SEG_W +: SEG_W];
  assign w_sel_oh = N_DIG'(1) << r_idx;

  always_ff @(posedge clk_disp or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_start <= 1'b0;
      r_catodo      <= SEG_OFF;
      r_sel         <= SEL_OFF;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_idx         <= w_idx_nx;
      r_frame_start <= w_fs;
      if (!enable) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (w_frame_wrap) begin
        if (r_frame_cnt == FR_LAST) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FR_W'(1);
        end
      end
      if (w_lit) begin
        r_catodo <= (ACT_LOW != 0) ? ~w_pat : w_pat;
        r_sel    <= (ACT_LOW != 0) ? ~w_sel_oh : w_sel_oh;
      end else begin
        r_catodo <= SEG_OFF;
        r_sel    <= SEL_OFF;
      end
    end
  end

  // Frame snapshot: data only, loaded before any lit cycle can use it.
  always_ff @(posedge clk_disp) begin
    if (w_fs) begin
      r_seg_s   <= seg_in;
      r_blank_s <= blank_mask;
      r_blink_s <= blink_mask;
      r_br_s    <= brightness;
    end
  end

  assign catodo      = r_catodo;
  assign seleccion   = r_sel;
  assign frame_start = r_frame_start;

endmodule
